// File: rtl/align_rshifter.sv
// Multi-cycle logical right aligner with sticky: one log2 stage (1,2,4,8..) per clock.
// Latency: SHW cycles from accept to out_valid (ALIGN_RSH_EARLY_EXIT_EN: highest set amt bit + 1).
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
module align_rshifter #(
    parameter int WIDTH = 11,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky
);

    localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sticky_q, sticky_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [KW-1:0]    k_q, k_d;

    logic [WIDTH-1:0] stage_data;
    logic             stage_lost;
    logic             last_stage;

    // Stage k shifts by 2^k; shifting by >= WIDTH naturally zeroes the word
    // and every bit of it falls into the sticky.
    always_comb begin
        stage_data = data_q;
        stage_lost = 1'b0;
        for (int i = 0; i < SHW; i++) begin
            if (k_q == KW'(i) && amt_q[i]) begin
                stage_data = data_q >> (1 << i);
                for (int b = 0; b < WIDTH; b++) begin
                    if (b < (1 << i)) begin
                        stage_lost = stage_lost | data_q[b];
                    end
                end
            end
        end
    end

`ifdef ALIGN_RSH_EARLY_EXIT_EN
    assign last_stage = ((amt_q >> (int'(k_q) + 1)) == '0);
`else
    assign last_stage = (k_q == KW'(SHW - 1));
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sticky_d = sticky_q;
        amt_d    = amt_q;
        k_d      = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    amt_d    = in_amt;
                    sticky_d = 1'b0;
                    k_d      = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                data_d   = stage_data;
                sticky_d = sticky_q | stage_lost;
                k_d      = k_q + KW'(1);
                if (last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            sticky_q <= 1'b0;
            amt_q    <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
            amt_q    <= amt_d;
            k_q      <= k_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_data   = data_q;
    assign out_sticky = sticky_q;

endmodule

// File: tb/tb_align_rshifter.sv
// Directed bench for align_rshifter: latency, shift/sticky results, hold, busy input, reset.
module tb_align_rshifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_data;
    logic [3:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic        out_sticky;

    int checks = 0;
    int fails  = 0;

    align_rshifter #(.WIDTH(11), .SHW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] amt);
`ifdef ALIGN_RSH_EARLY_EXIT_EN
        int p = 0;
        for (int i = 0; i < 4; i++) if (amt[i]) p = i;
        return p + 1;
`else
        return 4;
`endif
    endfunction

    // Accept one operand, wait for out_valid (bounded), check result,
    // optionally stall the output, then complete the handshake.
    task automatic run_op(input string tag, input logic [10:0] d, input logic [3:0] a,
                          input logic [10:0] ed, input logic es, input int stall);
        int lat = 0;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 11'h7ff;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},    32'(lat),        32'(exp_lat(a)));
        chk({tag, "_data"},   32'(out_data),   32'(ed));
        chk({tag, "_sticky"}, 32'(out_sticky), 32'(es));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_vld"},    32'(out_valid),  32'd1);
            chk({tag, "_hold_data"},   32'(out_data),   32'(ed));
            chk({tag, "_hold_sticky"}, 32'(out_sticky), 32'(es));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_vld"},   32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_out_data",  32'(out_data),   32'd0);
        chk("rst_sticky",    32'(out_sticky), 32'd0);

        run_op("basic",   11'b00110111011, 4'd3,  11'b00000110111, 1'b1, 3);
        run_op("zero",    11'b00110111011, 4'd0,  11'b00110111011, 1'b0, 0);
        run_op("exact10", 11'b10000000000, 4'd10, 11'b00000000001, 1'b0, 0);
        run_op("over11",  11'b00000000001, 4'd11, 11'b00000000000, 1'b1, 0);
        run_op("over15",  11'b00000000000, 4'd15, 11'b00000000000, 1'b0, 0);
        run_op("amt1",    11'b00000000010, 4'd1,  11'b00000000001, 1'b0, 0);
        run_op("amt5",    11'b11111111111, 4'd5,  11'b00000111111, 1'b1, 0);
        run_op("amt8",    11'b11100000000, 4'd8,  11'b00000000111, 1'b0, 0);

        // Busy input: a second operand offered while shifting must be ignored.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 11'b10110000000;
        in_amt    = 4'd7;
        @(posedge clk); #1;
        in_data = 11'b11111111111;
        in_amt  = 4'd0;
        out_ready = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_lat",    32'(lat),        32'(exp_lat(4'd7)));
        chk("busy_data",   32'(out_data),   32'(11'b00000001011));
        chk("busy_sticky", 32'(out_sticky), 32'd0);
        chk("busy_done_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("busy_post_vld", 32'(out_valid), 32'd0);

        // Reset during the second SHIFT cycle discards the operand.
        in_valid = 1'b1;
        in_data  = 11'b11111111111;
        in_amt   = 4'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready",  32'(in_ready),   32'd1);
        chk("mid_rst_out_valid", 32'(out_valid),  32'd0);
        chk("mid_rst_out_data",  32'(out_data),   32'd0);
        chk("mid_rst_sticky",    32'(out_sticky), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
        end

        run_op("after_rst", 11'b00000001100, 4'd2, 11'b00000000011, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
